// File: rtl/line_buffer_scheduler_pkg.sv
// Shared definitions for the stereo line-buffer write scheduler:
// slot count, state encoding and slot rotation.
package line_buffer_scheduler_pkg;

  localparam int NUM_SLOTS = 5;
  localparam int SLOT_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    BUSY = 2'd2
  } state_t;

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot);
    return (slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/line_buffer_scheduler_side_write_counter.sv
// One side (left or right) of the write path: pixel count, ready/full status
// and the registered write strobe, address and data for that side's buffer.
module side_write_counter #(
  parameter int LINE_WIDTH = 640,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              yield_to_other,
  input  logic              valid,
  input  logic [DATA_W-1:0] pixel,
  output logic              ready,
  output logic              full,
  output logic              strobe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  localparam int CNT_W = $clog2(LINE_WIDTH + 1);

  logic [CNT_W-1:0]  count_reg;
  logic              strobe_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [DATA_W-1:0] data_reg;
  logic              accept;

  assign full   = (count_reg == CNT_W'(LINE_WIDTH));
  assign ready  = enable && !full && !yield_to_other;
  assign accept = valid && ready;

  // A clear (row wrap or frame restart) wins over a same-cycle accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg   <= '0;
      strobe_reg  <= 1'b0;
      address_reg <= '0;
      data_reg    <= '0;
    end else begin
      strobe_reg <= accept && !clear;
      if (clear) begin
        count_reg <= '0;
      end else if (accept) begin
        count_reg   <= count_reg + CNT_W'(1);
        address_reg <= ADDR_W'(count_reg);
        data_reg    <= pixel;
      end
    end
  end

  assign strobe  = strobe_reg;
  assign address = address_reg;
  assign data    = data_reg;

endmodule

// File: rtl/line_buffer_scheduler.sv
// Write-side controller for the five-slot stereo line buffers: merges the two
// pixel streams onto one write port, rotates the slot select and hands
// complete five-row windows to the read pipeline.
module line_buffer_scheduler
  import line_buffer_scheduler_pkg::*;
#(
  parameter int LINE_WIDTH      = 640,
  parameter int LINES_PER_FRAME = 480,
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pixel_valid_left,
  input  logic              pixel_valid_right,
  input  logic [DATA_W-1:0] pixel_data_left,
  input  logic [DATA_W-1:0] pixel_data_right,
  output logic              pixel_ready_left,
  output logic              pixel_ready_right,
  input  logic              read_done,
  output logic              left_enable,
  output logic              right_enable,
  output logic [ADDR_W-1:0] address_in,
  output logic [DATA_W-1:0] data_in,
  output logic [2:0]        select,
  output logic              read_start,
  output logic              busy,
  output logic              frame_done
);

  localparam int ROW_W = $clog2(LINES_PER_FRAME + 1);

  state_t            state_reg, state_next;
  logic [ROW_W-1:0]  row_reg;
  logic [SLOT_W-1:0] slots_reg, slots_inc, select_reg;
  logic              read_start_reg, read_start_next;
  logic              frame_done_reg, frame_done_next;
  logic              fill_active, row_complete, window_ready, last_row, counter_clear;
  logic              left_ready, right_ready, left_full, right_full;
  logic              left_strobe, right_strobe, right_yield;
  logic [ADDR_W-1:0] left_address, right_address;
  logic [DATA_W-1:0] left_data, right_data;

  assign row_complete  = (state_reg == FILL) && left_full && right_full;
  assign slots_inc     = (slots_reg == SLOT_W'(NUM_SLOTS)) ? slots_reg : slots_reg + SLOT_W'(1);
  assign window_ready  = row_complete && (slots_inc == SLOT_W'(NUM_SLOTS));
  assign last_row      = (row_reg == ROW_W'(LINES_PER_FRAME));
  assign counter_clear = frame_start || row_complete;
  // Left has priority on the shared write port.
  assign right_yield   = pixel_valid_left && left_ready;

  side_write_counter #(
    .LINE_WIDTH(LINE_WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) u_left (
    .clock(clock), .reset(reset), .enable(fill_active), .clear(counter_clear),
    .yield_to_other(1'b0), .valid(pixel_valid_left), .pixel(pixel_data_left),
    .ready(left_ready), .full(left_full), .strobe(left_strobe),
    .address(left_address), .data(left_data)
  );

  side_write_counter #(
    .LINE_WIDTH(LINE_WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) u_right (
    .clock(clock), .reset(reset), .enable(fill_active), .clear(counter_clear),
    .yield_to_other(right_yield), .valid(pixel_valid_right), .pixel(pixel_data_right),
    .ready(right_ready), .full(right_full), .strobe(right_strobe),
    .address(right_address), .data(right_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      read_start_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      read_start_reg <= read_start_next;
      frame_done_reg <= frame_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (frame_start) state_next = FILL;
      FILL: begin
        if (frame_start)       state_next = FILL;
        else if (window_ready) state_next = BUSY;
      end
      BUSY: begin
        if (frame_start)    state_next = FILL;
        else if (read_done) state_next = last_row ? IDLE : FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fill_active     = (state_reg == FILL);
    busy            = (state_reg == BUSY);
    read_start_next = window_ready && !frame_start;
    frame_done_next = (state_reg == BUSY) && read_done && !frame_start && last_row;
  end

  // Row bookkeeping: a frame restart clears everything, a finished row rotates the slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_reg    <= '0;
      slots_reg  <= '0;
      select_reg <= '0;
    end else if (frame_start) begin
      row_reg    <= '0;
      slots_reg  <= '0;
      select_reg <= '0;
    end else if (row_complete) begin
      row_reg    <= row_reg + ROW_W'(1);
      slots_reg  <= slots_inc;
      select_reg <= next_slot(select_reg);
    end
  end

  assign pixel_ready_left  = left_ready;
  assign pixel_ready_right = right_ready;
  assign left_enable       = left_strobe;
  assign right_enable      = right_strobe;
  assign address_in        = left_strobe ? left_address : right_address;
  assign data_in           = left_strobe ? left_data : right_data;
  assign select            = select_reg;
  assign read_start        = read_start_reg;
  assign frame_done        = frame_done_reg;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Randomized scenario bench for line_buffer_scheduler with a small
// behavioural model of row/slot progress and left-priority arbitration.
module tb_line_buffer_scheduler;

  localparam int LW  = 4;
  localparam int LPF = 7;
  localparam int AW  = 10;
  localparam int DW  = 8;

  logic          clock = 1'b0;
  logic          reset, frame_start, read_done;
  logic          pixel_valid_left, pixel_valid_right;
  logic [DW-1:0] pixel_data_left, pixel_data_right;
  logic          pixel_ready_left, pixel_ready_right;
  logic          left_enable, right_enable, read_start, busy, frame_done;
  logic [AW-1:0] address_in;
  logic [DW-1:0] data_in;
  logic [2:0]    select;

  int checks   = 0;
  int failures = 0;
  int m_rows   = 0;

  always #5 clock = ~clock;

  line_buffer_scheduler #(
    .LINE_WIDTH(LW), .LINES_PER_FRAME(LPF), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .pixel_valid_left(pixel_valid_left), .pixel_valid_right(pixel_valid_right),
    .pixel_data_left(pixel_data_left), .pixel_data_right(pixel_data_right),
    .pixel_ready_left(pixel_ready_left), .pixel_ready_right(pixel_ready_right),
    .read_done(read_done), .left_enable(left_enable), .right_enable(right_enable),
    .address_in(address_in), .data_in(data_in), .select(select),
    .read_start(read_start), .busy(busy), .frame_done(frame_done)
  );

  // Drive one cycle of inputs, sample readies mid-cycle, return 1 time unit after the edge.
  task automatic tick(input logic vl, input logic vr, input logic [DW-1:0] dl,
                      input logic [DW-1:0] dr, input logic fs, input logic rd,
                      output logic rl, output logic rr);
    pixel_valid_left  = vl;
    pixel_valid_right = vr;
    pixel_data_left   = dl;
    pixel_data_right  = dr;
    frame_start       = fs;
    read_done         = rd;
    #1;
    rl = pixel_ready_left;
    rr = pixel_ready_right;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    logic a, b;
    repeat (n) tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, a, b);
  endtask

  task automatic fill_row_simple();
    logic a, b;
    for (int i = 0; i < LW; i++) tick(1'b1, 1'b0, 8'($urandom_range(1, 255)), '0, 1'b0, 1'b0, a, b);
    for (int i = 0; i < LW; i++) tick(1'b0, 1'b1, '0, 8'($urandom_range(1, 255)), 1'b0, 1'b0, a, b);
    idle(1);
  endtask

  task automatic test_reset();
    logic rl, rr;
    reset = 1'b1;
    idle(2);
    checks++;
    if ({left_enable, right_enable, read_start, busy, frame_done, pixel_ready_left, pixel_ready_right} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000000",
               {left_enable, right_enable, read_start, busy, frame_done, pixel_ready_left, pixel_ready_right});
    end
    checks++;
    if (select !== 3'd0 || address_in !== '0 || data_in !== '0) begin
      failures++;
      $display("FAIL reset_values: select=%0d addr=%0d data=%0d required 0 0 0", select, address_in, data_in);
    end
    reset = 1'b0;
    tick(1'b1, 1'b1, 8'h5a, 8'ha5, 1'b0, 1'b0, rl, rr);
    checks++;
    if (rl !== 1'b0 || rr !== 1'b0 || left_enable !== 1'b0 || right_enable !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_accept: ready=%b%b strobe=%b%b required 00 00", rl, rr, left_enable, right_enable);
    end
  endtask

  task automatic test_prime();
    logic rl, rr;
    logic [DW-1:0] d;
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rl, rr);
    m_rows = 0;
    for (int r = 1; r <= 5; r++) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < LW; i++) begin
          idle($urandom_range(0, 1));
          d = 8'($urandom);
          tick(s == 0, s == 1, d, d, 1'b0, 1'b0, rl, rr);
          checks++;
          if (((s == 0) ? rl : rr) !== 1'b1) begin
            failures++;
            $display("FAIL prime_ready: row %0d side %0d pixel %0d ready=%b required 1", r, s, i, (s == 0) ? rl : rr);
          end
          checks++;
          if (left_enable !== (s == 0) || right_enable !== (s == 1) || address_in !== AW'(i) || data_in !== d) begin
            failures++;
            $display("FAIL prime_write: row %0d side %0d strobe=%b%b addr=%0d data=%h required strobe=%b%b addr=%0d data=%h",
                     r, s, left_enable, right_enable, address_in, data_in, s == 0, s == 1, i, d);
          end
          checks++;
          if (select !== 3'(m_rows % 5)) begin
            failures++;
            $display("FAIL prime_select_hold: row %0d select=%0d required %0d", r, select, m_rows % 5);
          end
        end
      end
      m_rows++;
      idle(1);
      checks++;
      if (select !== 3'(m_rows % 5)) begin
        failures++;
        $display("FAIL prime_select: after row %0d select=%0d required %0d", r, select, m_rows % 5);
      end
      checks++;
      if (read_start !== (m_rows == 5) || busy !== (m_rows == 5)) begin
        failures++;
        $display("FAIL prime_window: after row %0d read_start=%b busy=%b required %b %b",
                 r, read_start, busy, m_rows == 5, m_rows == 5);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic rl, rr;
    int n;
    n = $urandom_range(3, 8);
    for (int k = 0; k < n; k++) begin
      tick(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, rl, rr);
      checks++;
      if (rl !== 1'b0 || rr !== 1'b0 || left_enable !== 1'b0 || right_enable !== 1'b0 ||
          busy !== 1'b1 || read_start !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold: cycle %0d ready=%b%b strobe=%b%b busy=%b read_start=%b required 00 00 1 0",
                 k, rl, rr, left_enable, right_enable, busy, read_start);
      end
    end
    tick(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1, rl, rr);
    checks++;
    if (pixel_ready_left !== 1'b1 || pixel_ready_right !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: ready=%b%b busy=%b required 10 0",
               pixel_ready_left, pixel_ready_right, busy);
    end
    checks++;
    if (rl !== 1'b0 || rr !== 1'b0 || left_enable !== 1'b0 || right_enable !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_done_cycle: ready=%b%b strobe=%b%b required 00 00", rl, rr, left_enable, right_enable);
    end
  endtask

  task automatic test_interleave();
    logic rl, rr, vl, vr, erl, err, al, ar;
    logic [DW-1:0] dl, dr;
    int lc, rc, n;
    for (int row = 6; row <= 7; row++) begin
      lc = 0; rc = 0; n = 0;
      dl = 8'($urandom); dr = 8'($urandom);
      while ((lc < LW || rc < LW) && n < 100) begin
        vl  = (row == 6) ? 1'b1 : 1'($urandom_range(0, 1));
        vr  = (row == 6) ? 1'b1 : 1'($urandom_range(0, 1));
        erl = (lc < LW);
        err = (rc < LW) && !(vl && erl);
        tick(vl, vr, dl, dr, 1'b0, 1'b0, rl, rr);
        checks++;
        if (rl !== erl || rr !== err) begin
          failures++;
          $display("FAIL interleave_ready: row %0d ready=%b%b required %b%b", row, rl, rr, erl, err);
        end
        al = vl && erl;
        ar = vr && err;
        checks++;
        if (left_enable !== al || right_enable !== ar) begin
          failures++;
          $display("FAIL interleave_strobe: row %0d strobe=%b%b required %b%b", row, left_enable, right_enable, al, ar);
        end
        if (al) begin
          checks++;
          if (address_in !== AW'(lc) || data_in !== dl) begin
            failures++;
            $display("FAIL interleave_left_write: addr=%0d data=%h required %0d %h", address_in, data_in, lc, dl);
          end
          lc++;
          dl = 8'($urandom);
        end else if (ar) begin
          checks++;
          if (address_in !== AW'(rc) || data_in !== dr) begin
            failures++;
            $display("FAIL interleave_right_write: addr=%0d data=%h required %0d %h", address_in, data_in, rc, dr);
          end
          rc++;
          dr = 8'($urandom);
        end
        n++;
      end
      checks++;
      if (n >= 100 || (row == 6 && n != 2 * LW)) begin
        failures++;
        $display("FAIL interleave_row_length: row %0d took %0d cycles, required %0d accepts to finish", row, n, 2 * LW);
      end
      m_rows++;
      idle(1);
      checks++;
      if (select !== 3'(m_rows % 5) || read_start !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL interleave_window: row %0d select=%0d read_start=%b busy=%b required %0d 1 1",
                 row, select, read_start, busy, m_rows % 5);
      end
      if (row == 6) begin
        tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rl, rr);
        checks++;
        if (pixel_ready_left !== 1'b1 || pixel_ready_right !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL interleave_resume: ready=%b%b busy=%b frame_done=%b required 11 0 0",
                   pixel_ready_left, pixel_ready_right, busy, frame_done);
        end
      end
    end
  endtask

  task automatic test_frame_end();
    logic rl, rr;
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rl, rr);
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_end_pulse: frame_done=%b busy=%b required 1 0", frame_done, busy);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, rl, rr);
      checks++;
      if (frame_done !== 1'b0 || rl !== 1'b0 || rr !== 1'b0 || left_enable !== 1'b0 ||
          right_enable !== 1'b0 || read_start !== 1'b0) begin
        failures++;
        $display("FAIL frame_end_idle: cycle %0d frame_done=%b ready=%b%b strobe=%b%b read_start=%b required 0 00 00 0",
                 k, frame_done, rl, rr, left_enable, right_enable, read_start);
      end
    end
  endtask

  task automatic test_abort_and_reset();
    logic rl, rr;
    logic [DW-1:0] d;
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rl, rr);
    fill_row_simple();
    fill_row_simple();
    checks++;
    if (select !== 3'd2) begin
      failures++;
      $display("FAIL abort_setup_select: select=%0d required 2", select);
    end
    tick(1'b1, 1'b0, 8'h11, '0, 1'b0, 1'b0, rl, rr);
    tick(1'b1, 1'b0, 8'h22, '0, 1'b0, 1'b0, rl, rr);
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rl, rr);
    checks++;
    if (select !== 3'd0 || pixel_ready_left !== 1'b1 || pixel_ready_right !== 1'b1 ||
        frame_done !== 1'b0 || read_start !== 1'b0) begin
      failures++;
      $display("FAIL abort_restart: select=%0d ready=%b%b frame_done=%b read_start=%b required 0 11 0 0",
               select, pixel_ready_left, pixel_ready_right, frame_done, read_start);
    end
    d = 8'($urandom_range(1, 255));
    tick(1'b1, 1'b0, d, '0, 1'b0, 1'b0, rl, rr);
    checks++;
    if (left_enable !== 1'b1 || address_in !== '0 || data_in !== d) begin
      failures++;
      $display("FAIL abort_count_cleared: strobe=%b addr=%0d data=%h required 1 0 %h", left_enable, address_in, data_in, d);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rl, rr);
    repeat (5) fill_row_simple();
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rl, rr);
    fill_row_simple();
    checks++;
    if (busy !== 1'b1 || select !== 3'd1) begin
      failures++;
      $display("FAIL reset_setup_busy: busy=%b select=%0d required 1 1", busy, select);
    end
    reset = 1'b1;
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, rl, rr);
    reset = 1'b0;
    checks++;
    if ({left_enable, right_enable, read_start, busy, frame_done, pixel_ready_left, pixel_ready_right} !== 7'b0 ||
        select !== 3'd0 || address_in !== '0 || data_in !== '0) begin
      failures++;
      $display("FAIL reset_in_busy: flags=%b select=%0d addr=%0d data=%h required 0000000 0 0 00",
               {left_enable, right_enable, read_start, busy, frame_done, pixel_ready_left, pixel_ready_right},
               select, address_in, data_in);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, rl, rr);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || read_start !== 1'b0 ||
        pixel_ready_left !== 1'b0 || pixel_ready_right !== 1'b0) begin
      failures++;
      $display("FAIL read_done_ignored: busy=%b frame_done=%b read_start=%b ready=%b%b required 0 0 0 00",
               busy, frame_done, read_start, pixel_ready_left, pixel_ready_right);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rl, rr);
    checks++;
    if (pixel_ready_left !== 1'b1 || pixel_ready_right !== 1'b1) begin
      failures++;
      $display("FAIL restart_after_reset: ready=%b%b required 11", pixel_ready_left, pixel_ready_right);
    end
  endtask

  initial begin
    reset             = 1'b1;
    frame_start       = 1'b0;
    read_done         = 1'b0;
    pixel_valid_left  = 1'b0;
    pixel_valid_right = 1'b0;
    pixel_data_left   = '0;
    pixel_data_right  = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_prime();
    test_back_pressure();
    test_interleave();
    test_frame_end();
    test_abort_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "time limit");
  end

endmodule
